// File: rtl/fft32_frame_sequencer_if.sv
// rtl/fft32_frame_sequencer_if.sv - sample, core and result signals of the FFT frame sequencer
interface fft32_frame_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_re;
  logic [DATA_W-1:0]     in_im;
  logic [32*DATA_W-1:0]  core_re;
  logic [32*DATA_W-1:0]  core_im;
  logic                  core_enable;
  logic                  core_ret;
  logic [32*OUT_W-1:0]   res_re;
  logic [32*OUT_W-1:0]   res_im;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_re;
  logic [OUT_W-1:0]      out_im;
  logic [4:0]            out_idx;
  logic                  out_last;
  logic                  err_timeout;
  logic [15:0]           frames_done;

  modport master (
    input  in_valid, in_re, in_im, core_ret, res_re, res_im, out_ready,
    output in_ready, core_re, core_im, core_enable, out_valid, out_re, out_im,
           out_idx, out_last, err_timeout, frames_done
  );

  modport slave (
    output in_valid, in_re, in_im, core_ret, res_re, res_im, out_ready,
    input  in_ready, core_re, core_im, core_enable, out_valid, out_re, out_im,
           out_idx, out_last, err_timeout, frames_done
  );
endinterface

// File: rtl/fft32_frame_sequencer.sv
// rtl/fft32_frame_sequencer.sv - loads 32 samples, runs the parallel FFT core, drains results serially
module fft32_frame_sequencer #(
  parameter int DATA_W  = 12,
  parameter int OUT_W   = 17,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  fft32_frame_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, RUN, CAPTURE} state_t;

  state_t            state, state_n;
  logic [4:0]        load_idx;
  logic [CW-1:0]     run_cnt;
  logic              err_q;
  logic [15:0]       frames_q;
  logic              ob_full;
  logic [4:0]        out_idx_q;
  logic              timeout_hit;
  logic              in_fire;
  logic              out_fire;

  logic [DATA_W-1:0] ib_re [32];
  logic [DATA_W-1:0] ib_im [32];
  logic [OUT_W-1:0]  ob_re [32];
  logic [OUT_W-1:0]  ob_im [32];

  assign in_fire  = (state == LOAD) && bus.in_valid;
  assign out_fire = ob_full && bus.out_ready;

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      LOAD: begin
        if (in_fire && load_idx == 5'd31) state_n = RUN;
      end
      RUN: begin
        // A finished core waits for the output buffer; the timer is frozen meanwhile.
        if (bus.core_ret) begin
          if (!ob_full) state_n = CAPTURE;
        end else if (run_cnt == CW'(TIMEOUT - 1)) begin
          state_n     = LOAD;
          timeout_hit = 1'b1;
        end
      end
      CAPTURE: state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      load_idx  <= 5'd0;
      run_cnt   <= '0;
      err_q     <= 1'b0;
      frames_q  <= 16'd0;
      ob_full   <= 1'b0;
      out_idx_q <= 5'd0;
    end else begin
      state <= state_n;
      if (in_fire) load_idx <= load_idx + 5'd1;
      if (state != RUN) run_cnt <= '0;
      else if (!bus.core_ret) run_cnt <= run_cnt + CW'(1);
      if (timeout_hit) err_q <= 1'b1;
      if (out_fire) begin
        out_idx_q <= out_idx_q + 5'd1;
        if (out_idx_q == 5'd31) ob_full <= 1'b0;
      end
      if (state == CAPTURE) begin
        ob_full  <= 1'b1;
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        ib_re[k] <= '0;
        ib_im[k] <= '0;
      end
    end else if (in_fire) begin
      ib_re[load_idx] <= bus.in_re;
      ib_im[load_idx] <= bus.in_im;
    end
  end

  // Result lanes need no reset: they are only visible while ob_full is set.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int k = 0; k < 32; k++) begin
        ob_re[k] <= bus.res_re[k*OUT_W +: OUT_W];
        ob_im[k] <= bus.res_im[k*OUT_W +: OUT_W];
      end
    end
  end

  always_comb begin
    bus.core_re = '0;
    bus.core_im = '0;
    for (int k = 0; k < 32; k++) begin
      bus.core_re[k*DATA_W +: DATA_W] = ib_re[k];
      bus.core_im[k*DATA_W +: DATA_W] = ib_im[k];
    end
  end

  assign bus.in_ready    = (state == LOAD);
  assign bus.core_enable = (state == RUN);
  assign bus.out_valid   = ob_full;
  assign bus.out_re      = ob_full ? ob_re[out_idx_q] : '0;
  assign bus.out_im      = ob_full ? ob_im[out_idx_q] : '0;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_last    = ob_full && (out_idx_q == 5'd31);
  assign bus.err_timeout = err_q;
  assign bus.frames_done = frames_q;
endmodule
